// File: rtl/if_mem_ctrl_pkg.sv
// Shared bus widths, enables and fetch-FSM encodings for the instruction-fetch
// memory controller.
package if_mem_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam int MEM_BYTE_BUS  = 8;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } if_mem_state_e;

  function automatic logic [1:0] byte_idx_next(input logic [1:0] k);
    return k + 2'd1;
  endfunction

endpackage

// File: rtl/if_mem_ctrl_byte_asm.sv
// Four-byte little-endian scratch register: bytes arrive one at a time and
// are dropped into their lane; clear wipes a partially built word.
module inst_byte_asm
  import if_mem_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      load,
  input  logic [1:0]                sel,
  input  logic [MEM_BYTE_BUS-1:0]   din,
  output logic [4*MEM_BYTE_BUS-1:0] word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (load) begin
      word[sel*MEM_BYTE_BUS +: MEM_BYTE_BUS] <= din;
    end
  end

endmodule

// File: rtl/if_mem_ctrl.sv
// Instruction-fetch memory responder: turns one pc request into four byte
// reads on the synchronous memory port and returns the assembled word.
module if_mem_ctrl
  import if_mem_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 17,
  parameter int ADDR_W        = INST_ADDR_BUS,
  parameter int INST_W        = INST_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [ADDR_W-1:0]       pc,
  input  logic                    flush,
  output logic                    req_ready,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_rd,
  input  logic [MEM_BYTE_BUS-1:0] mem_din,
  output logic [INST_W-1:0]       inst,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic                    inst_valid
);

  if_mem_state_e            state;
  logic [1:0]               issue_cnt;
  logic [1:0]               cap_cnt;
  logic                     rd_d1;
  logic [MEM_ADDR_BITS-1:0] base;
  logic [MEM_ADDR_BITS-1:0] pc_base;
  logic [MEM_ADDR_BITS-1:0] next_addr;
  logic [1:0]               issue_nxt;
  logic [4*MEM_BYTE_BUS-1:0] asm_word;
  logic                     unused_bits;

  assign req_ready = (state == IDLE) && rst && !flush;
  assign pc_base   = {pc[MEM_ADDR_BITS-1:2], 2'b00};
  assign issue_nxt = byte_idx_next(issue_cnt);
  // Byte addresses wrap inside the physical memory; upper mem_a bits stay 0.
  assign next_addr = base + MEM_ADDR_BITS'(issue_nxt);
  assign unused_bits = ^{pc[ADDR_W-1:MEM_ADDR_BITS], pc[1:0], asm_word[31:24]};

  // Read data lags the strobe by one cycle, so rd_d1 marks the edge where
  // mem_din carries the byte for lane cap_cnt.
  inst_byte_asm u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (rd_d1 && !flush),
    .sel  (cap_cnt),
    .din  (mem_din),
    .word (asm_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      rd_d1      <= DISABLE;
      base       <= '0;
      mem_a      <= '0;
      mem_rd     <= DISABLE;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= DISABLE;
    end else begin
      inst_valid <= DISABLE;
      if (flush) begin
        state     <= IDLE;
        mem_rd    <= DISABLE;
        issue_cnt <= '0;
        cap_cnt   <= '0;
        rd_d1     <= DISABLE;
      end else begin
        rd_d1 <= mem_rd;
        // The last byte is taken straight from mem_din at completion.
        if (rd_d1) begin
          cap_cnt <= byte_idx_next(cap_cnt);
          if (cap_cnt == 2'd3) begin
            inst       <= INST_W'({mem_din, asm_word[23:0]});
            inst_pc    <= ADDR_W'(base);
            inst_valid <= ENABLE;
          end
        end
        case (state)
          IDLE: begin
            if (ce) begin
              base      <= pc_base;
              mem_a     <= ADDR_W'(pc_base);
              mem_rd    <= ENABLE;
              issue_cnt <= '0;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            if (issue_cnt == 2'd3) begin
              mem_rd <= DISABLE;
              state  <= DRAIN;
            end else begin
              issue_cnt <= issue_nxt;
              mem_a     <= ADDR_W'(next_addr);
            end
          end
          DRAIN:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Self-checking bench for if_mem_ctrl: byte memory model plus a word-level
// reference of what each fetch must return and when.
module tb_if_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic        flush;
  logic        req_ready;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:131071];

  logic [31:0] obs_a  [0:10];
  logic [10:0] obs_rd;
  logic [10:0] obs_v;
  logic [10:0] obs_rr;
  logic [31:0] obs_inst;
  logic [31:0] obs_pc;
  logic        obs_rr0;

  if_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .pc         (pc),
    .flush      (flush),
    .req_ready  (req_ready),
    .mem_a      (mem_a),
    .mem_rd     (mem_rd),
    .mem_din    (mem_din),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory; upper address bits must be zero to hit it.
  always @(posedge clk) begin
    if (mem_rd) mem_din <= (mem_a[31:17] == 15'd0) ? mem[mem_a[16:0]] : 8'hxx;
  end

  function automatic logic [31:0] ref_base(input logic [31:0] p);
    return {15'd0, p[16:2], 2'b00};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] p);
    logic [16:0] b;
    b = {p[16:2], 2'b00};
    return {mem[b + 17'd3], mem[b + 17'd2], mem[b + 17'd1], mem[b]};
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] p, input int k);
    logic [16:0] b;
    b = {p[16:2], 2'b00} + 17'(k);
    return {15'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge and records 11 post-edge samples.
  task automatic fetch_observe(input logic [31:0] p);
    obs_rr0 = req_ready;
    obs_inst = 32'hxxxxxxxx;
    obs_pc = 32'hxxxxxxxx;
    ce = 1'b1;
    pc = p;
    step();
    ce = 1'b0;
    pc = $urandom;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      obs_a[i]  = mem_a;
      obs_rd[i] = mem_rd;
      obs_v[i]  = inst_valid;
      obs_rr[i] = req_ready;
      if (inst_valid) begin
        obs_inst = inst;
        obs_pc   = inst_pc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b1; pc = 32'h10; flush = 1'b0;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", req_ready); end
    step(); step();
    total++; if (mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_rd got=%b want=0", mem_rd); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", inst_valid); end
    total++; if (inst !== 32'd0 || inst_pc !== 32'd0 || mem_a !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_regs got inst=%h pc=%h a=%h want all 0", inst, inst_pc, mem_a);
    end
    ce = 1'b0;
    rst = 1'b1;
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_reset got=%b want=1", req_ready); end
  endtask

  task automatic test_basic();
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    fetch_observe(32'h0);
    total++; if (obs_rr0 !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready got=%b want=1", obs_rr0); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_a[k] !== 32'(k)) begin bad++; $display("[TB] FAIL basic_addr%0d got=%h want=%h", k, obs_a[k], k); end
    end
    total++; if (obs_a[4] !== 32'd3) begin bad++; $display("[TB] FAIL basic_addr_hold got=%h want=3", obs_a[4]); end
    total++; if (obs_rd !== 11'b00000001111) begin bad++; $display("[TB] FAIL basic_rd got=%b want=00000001111", obs_rd); end
    total++; if (obs_v !== 11'b00000100000) begin bad++; $display("[TB] FAIL basic_valid got=%b want=00000100000", obs_v); end
    total++; if (obs_rr !== 11'b11111100000) begin bad++; $display("[TB] FAIL basic_ready_seq got=%b want=11111100000", obs_rr); end
    total++; if (obs_inst !== 32'h00000013) begin bad++; $display("[TB] FAIL basic_inst got=%h want=00000013", obs_inst); end
    total++; if (obs_pc !== 32'h0) begin bad++; $display("[TB] FAIL basic_pc got=%h want=0", obs_pc); end
    total++; if (inst !== 32'h00000013) begin bad++; $display("[TB] FAIL basic_inst_hold got=%h want=00000013", inst); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int vld[$];
    logic [31:0] words[$];
    logic [31:0] pcs[$];
    int low_between;
    logic accepting;
    mem[4] = 8'hB3; mem[5] = 8'h00; mem[6] = 8'h10; mem[7] = 8'h00;
    low_between = 0;
    ce = 1'b1; pc = 32'h0;
    for (int e = 0; e < 16; e++) begin
      accepting = ce && req_ready;
      step();
      if (accepting) begin
        acc.push_back(e);
        if (acc.size() == 1) pc = 32'h4;
        else ce = 1'b0;
      end
      if (acc.size() == 1 && !req_ready) low_between++;
      if (inst_valid) begin
        vld.push_back(e);
        words.push_back(inst);
        pcs.push_back(inst_pc);
      end
    end
    total++;
    if (acc.size() != 2 || vld.size() != 2) begin
      bad++; $display("[TB] FAIL b2b_counts got acc=%0d valid=%0d want 2/2", acc.size(), vld.size());
    end else begin
      total++; if (acc[1] - acc[0] != 6) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=6", acc[1] - acc[0]); end
      total++; if (vld[0] - acc[0] != 5 || vld[1] - acc[1] != 5) begin
        bad++; $display("[TB] FAIL b2b_latency got=%0d/%0d want=5/5", vld[0] - acc[0], vld[1] - acc[1]);
      end
      total++; if (words[0] !== 32'h00000013 || pcs[0] !== 32'h0) begin
        bad++; $display("[TB] FAIL b2b_first got inst=%h pc=%h want 00000013/0", words[0], pcs[0]);
      end
      total++; if (words[1] !== 32'h001000B3 || pcs[1] !== 32'h4) begin
        bad++; $display("[TB] FAIL b2b_second got inst=%h pc=%h want 001000b3/4", words[1], pcs[1]);
      end
    end
    total++; if (low_between != 5) begin bad++; $display("[TB] FAIL b2b_ready_low got=%0d want=5", low_between); end
    ce = 1'b0;
    step();
  endtask

  task automatic test_masked();
    logic [31:0] p;
    p = 32'hFFFF0006;
    fetch_observe(p);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_a[k] !== 32'h00010004 + 32'(k)) begin
        bad++; $display("[TB] FAIL masked_addr%0d got=%h want=%h", k, obs_a[k], 32'h00010004 + 32'(k));
      end
    end
    total++; if (obs_pc !== 32'h00010004) begin bad++; $display("[TB] FAIL masked_pc got=%h want=00010004", obs_pc); end
    total++; if (obs_inst !== ref_word(p)) begin bad++; $display("[TB] FAIL masked_inst got=%h want=%h", obs_inst, ref_word(p)); end
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int n = 0; n < 10; n++) begin
      p = (n == 0) ? 32'hFFFFFFFF : (n == 1) ? 32'h0001FFFC : $urandom;
      fetch_observe(p);
      total++; if (obs_v !== 11'b00000100000) begin bad++; $display("[TB] FAIL rand%0d_valid got=%b want=00000100000", n, obs_v); end
      total++; if (obs_a[0] !== ref_addr(p, 0) || obs_a[3] !== ref_addr(p, 3)) begin
        bad++; $display("[TB] FAIL rand%0d_addr got=%h..%h want=%h..%h", n, obs_a[0], obs_a[3], ref_addr(p, 0), ref_addr(p, 3));
      end
      total++; if (obs_inst !== ref_word(p)) begin bad++; $display("[TB] FAIL rand%0d_inst got=%h want=%h", n, obs_inst, ref_word(p)); end
      total++; if (obs_pc !== ref_base(p)) begin bad++; $display("[TB] FAIL rand%0d_pc got=%h want=%h", n, obs_pc, ref_base(p)); end
    end
  endtask

  task automatic test_flush_mid();
    logic [31:0] prev_inst, prev_pc;
    int pulses;
    prev_inst = inst; prev_pc = inst_pc; pulses = 0;
    ce = 1'b1; pc = 32'h20;
    step();
    ce = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL flush_mid_rd got=%b want=0", mem_rd); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (inst_valid) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL flush_mid_valid got=%0d pulses want=0", pulses); end
    total++; if (inst !== prev_inst || inst_pc !== prev_pc) begin
      bad++; $display("[TB] FAIL flush_mid_hold got=%h/%h want=%h/%h", inst, inst_pc, prev_inst, prev_pc);
    end
    fetch_observe(32'h8);
    total++; if (obs_v !== 11'b00000100000) begin bad++; $display("[TB] FAIL after_flush_valid got=%b want=00000100000", obs_v); end
    total++; if (obs_inst !== ref_word(32'h8) || obs_pc !== 32'h8) begin
      bad++; $display("[TB] FAIL after_flush_inst got=%h/%h want=%h/8", obs_inst, obs_pc, ref_word(32'h8));
    end
  endtask

  task automatic test_flush_completion();
    logic [31:0] prev_inst, prev_pc;
    int rd_seen;
    prev_inst = inst; prev_pc = inst_pc; rd_seen = 0;
    ce = 1'b1; pc = 32'h40;
    step();
    ce = 1'b0;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_e5_valid got=%b want=0", inst_valid); end
    total++; if (inst !== prev_inst || inst_pc !== prev_pc) begin
      bad++; $display("[TB] FAIL flush_e5_hold got=%h/%h want=%h/%h", inst, inst_pc, prev_inst, prev_pc);
    end
    ce = 1'b1; pc = 32'h44;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ce_ready got=%b want=0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_rd || inst_valid) rd_seen++;
    end
    total++; if (rd_seen != 0) begin bad++; $display("[TB] FAIL flush_ce_accept got=%0d active cycles want=0", rd_seen); end
    flush = 1'b0; ce = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    ce = 1'b1; pc = 32'h80;
    step();
    ce = 1'b0;
    step(); step();
    #2 rst = 1'b0;
    #1;
    total++; if (mem_rd !== 1'b0 || inst_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset got rd=%b v=%b rdy=%b want 0/0/0", mem_rd, inst_valid, req_ready);
    end
    total++; if (inst !== 32'd0 || mem_a !== 32'd0) begin
      bad++; $display("[TB] FAIL async_reset_regs got inst=%h a=%h want 0/0", inst, mem_a);
    end
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (inst_valid) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL async_reset_partial got=%0d pulses want=0", pulses); end
    fetch_observe(32'h80);
    total++; if (obs_inst !== ref_word(32'h80) || obs_pc !== 32'h80) begin
      bad++; $display("[TB] FAIL async_reset_fetch got=%h/%h want=%h/80", obs_inst, obs_pc, ref_word(32'h80));
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem_din = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_masked();
    test_random();
    test_flush_mid();
    test_flush_completion();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
